instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_pkg.sv | 23 ++
 rtl/loader_checksum.sv | 37 +++
 rtl/instruction_loader.sv | 165 ++++++++++++++++
 tb/tb_instruction_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader_pkg
// Brief    : Shared constants and FSM state encoding for the instruction loader.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_loader_pkg;

    // Instruction word width and default first-word address (fetch reset PC)
    localparam int          c_WORD_W    = 16;
    localparam logic [31:0] c_BASE_ADDR = 32'h20;

    // Loader FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CHK    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/loader_checksum.sv
`default_nettype none
// ============================================================================
// Module   : loader_checksum
// Brief    : Running modulo-2^WORD_W sum of the loaded instruction words.
//            Only instantiated when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module loader_checksum
    import instruction_loader_pkg::*;
#(
    parameter int WORD_W = c_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] sum
);

    logic [WORD_W-1:0] r_sum;

    // Accumulate each accepted instruction word; cleared when a new load starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (clr) begin
            r_sum <= '0;
        end else if (en) begin
            r_sum <= r_sum + data;
        end
    end

    assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader
// Brief    : Streams a header (word count N), N instruction words and an
//            optional checksum word into the instruction-memory write port,
//            writing word k to BASE_ADDR+k one cycle after it is accepted.
//            Optional feature macro: INSTRUCTION_LOADER_CHECKSUM_EN
// Revision : 1.0 - initial release
// ============================================================================
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = c_BASE_ADDR,
    parameter int          WORD_W    = c_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              write_enable,
    output logic [31:0]       write_addr,
    output logic [WORD_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              load_error
);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    localparam state_e c_ST_AFTER_LOAD = ST_CHK;
`else
    localparam state_e c_ST_AFTER_LOAD = ST_DONE;
`endif

    state_e            r_state;
    state_e            w_next;
    logic              w_accept;
    logic [15:0]       w_hdr_n;
    logic [15:0]       r_n;
    logic [15:0]       r_k;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [WORD_W-1:0] r_data;

    assign w_accept = in_valid & in_ready;
    assign w_hdr_n  = 16'(in_data);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) begin
                    w_next = (w_hdr_n == 16'd0) ? c_ST_AFTER_LOAD : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && (r_k == r_n - 16'd1)) begin
                    w_next = c_ST_AFTER_LOAD;
                end
            end
            ST_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Word counter and registered memory write port; address holds after the last write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n    <= 16'd0;
            r_k    <= 16'd0;
            r_we   <= 1'b0;
            r_addr <= BASE_ADDR;
            r_data <= '0;
        end else begin
            r_we <= 1'b0;
            if ((r_state == ST_HEADER) && w_accept) begin
                r_n <= w_hdr_n;
                r_k <= 16'd0;
            end
            if ((r_state == ST_LOAD) && w_accept) begin
                r_we   <= 1'b1;
                r_addr <= BASE_ADDR + {16'd0, r_k};
                r_data <= in_data;
                r_k    <= r_k + 16'd1;
            end
        end
    end

    assign write_enable = r_we;
    assign write_addr   = r_addr;
    assign write_data   = r_data;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic              w_start_acc;
    logic              w_load_acc;
    logic [WORD_W-1:0] w_sum;
    logic              r_err;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_load_acc  = (r_state == ST_LOAD) && w_accept;

    loader_checksum #(
        .WORD_W (WORD_W)
    ) u_checksum (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_start_acc),
        .en   (w_load_acc),
        .data (in_data),
        .sum  (w_sum)
    );

    // Checksum verdict, latched on the CHK word and held until the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_CHK) && w_accept) begin
            r_err <= (in_data != w_sum);
        end
    end

    assign load_error = r_err;
`else
    assign load_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_loader
// Brief    : Self-checking bench for instruction_loader. Two instances share
//            stimulus: default BASE_ADDR and BASE_ADDR=32'hFFFFFFFF (wrap).
//            Honours INSTRUCTION_LOADER_CHECKSUM_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

    localparam int          W      = 16;
    localparam logic [31:0] BASE_A = 32'h20;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFFF;

    typedef logic [W-1:0] word_q_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [W-1:0]  in_data;

    logic          in_ready_a, we_a, busy_a, done_a, err_a;
    logic [31:0]   wa_a;
    logic [W-1:0]  wd_a;
    logic          in_ready_b, we_b, busy_b, done_b, err_b;
    logic [31:0]   wa_b;
    logic [W-1:0]  wd_b;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0]  mon_addr_a[$];
    logic [31:0]  mon_addr_b[$];
    logic [W-1:0] mon_data_a[$];
    logic [W-1:0] mon_data_b[$];
    int           done_cnt_a = 0;
    int           done_cnt_b = 0;

    always #5 clk = ~clk;

    instruction_loader #(.BASE_ADDR(BASE_A), .WORD_W(W)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .write_enable(we_a), .write_addr(wa_a), .write_data(wd_a),
        .busy(busy_a), .done(done_a), .load_error(err_a)
    );

    instruction_loader #(.BASE_ADDR(BASE_B), .WORD_W(W)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .write_enable(we_b), .write_addr(wa_b), .write_data(wd_b),
        .busy(busy_b), .done(done_b), .load_error(err_b)
    );

    // Record every memory write and done pulse shortly after each rising edge
    always begin
        @(posedge clk);
        #2;
        if (we_a === 1'b1) begin
            mon_addr_a.push_back(wa_a);
            mon_data_a.push_back(wd_a);
        end
        if (we_b === 1'b1) begin
            mon_addr_b.push_back(wa_b);
            mon_data_b.push_back(wd_b);
        end
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitor();
        mon_addr_a.delete();
        mon_addr_b.delete();
        mon_data_a.delete();
        mon_data_b.delete();
        done_cnt_a = 0;
        done_cnt_b = 0;
    endtask

    // Offer one word (called just after a falling edge); for a LOAD word, check
    // the write in the cycle right after acceptance.
    task automatic send_word(input logic [W-1:0] w, input bit is_load, input int k);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready_a !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", {31'd0, in_ready_a}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (is_load) begin
            check("we_a_latency", {31'd0, we_a}, 32'd1);
            check("wa_a", wa_a, BASE_A + 32'(k));
            check("wd_a", {16'd0, wd_a}, {16'd0, w});
            check("we_b_latency", {31'd0, we_b}, 32'd1);
            check("wa_b_wrap", wa_b, BASE_B + 32'(k));
        end
    endtask

    // One complete load. gap >= 0: fixed idle cycles before each word; gap < 0: random 0..3.
    // delta: added to the true checksum (non-zero means a corrupt checksum).
    task automatic do_load(input word_q_t words, input int gap, input logic [W-1:0] delta);
        int           n;
        int           g;
        int           i;
        logic [W-1:0] sum;
        logic [W-1:0] hdr;
        bit           exp_err;
        n   = words.size();
        sum = '0;
        hdr = W'(n);
        clear_monitor();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy_a}, 32'd1);
        check("err_cleared_on_start", {31'd0, err_a}, 32'd0);
        send_word(hdr, 1'b0, 0);
        for (int k = 0; k < n; k++) begin
            g = (gap >= 0) ? gap : int'($urandom_range(3, 0));
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                start    = 1'($urandom);
                @(negedge clk);
                check("in_ready_stall", {31'd0, in_ready_a}, 32'd1);
            end
            start = 1'b0;
            sum   = sum + words[k];
            send_word(words[k], 1'b1, k);
        end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        send_word(sum + delta, 1'b0, 0);
        exp_err = (delta != '0);
`else
        exp_err = 1'b0;
`endif
        i = 0;
        while (done_cnt_a == 0 && i < 10) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", 32'(done_cnt_a), 32'd1);
        repeat (2) @(negedge clk);
        check("done_pulse_a", 32'(done_cnt_a), 32'd1);
        check("done_pulse_b", 32'(done_cnt_b), 32'd1);
        check("busy_idle", {31'd0, busy_a}, 32'd0);
        check("load_error_a", {31'd0, err_a}, {31'd0, exp_err});
        check("load_error_b", {31'd0, err_b}, {31'd0, exp_err});
        check("write_count_a", 32'(mon_addr_a.size()), 32'(n));
        check("write_count_b", 32'(mon_addr_b.size()), 32'(n));
        for (int k = 0; k < n && k < mon_addr_a.size() && k < mon_addr_b.size(); k++) begin
            check("mon_addr_a", mon_addr_a[k], BASE_A + 32'(k));
            check("mon_data_a", {16'd0, mon_data_a[k]}, {16'd0, words[k]});
            check("mon_addr_b", mon_addr_b[k], BASE_B + 32'(k));
        end
        if (n > 0) begin
            check("addr_hold_a", wa_a, BASE_A + 32'(n - 1));
            check("addr_hold_b", wa_b, BASE_B + 32'(n - 1));
        end
    endtask

    task automatic random_words(input int n, output word_q_t q);
        q.delete();
        for (int k = 0; k < n; k++) q.push_back(W'($urandom));
    endtask

    initial begin
        word_q_t q;
        logic [W-1:0] d;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_we", {31'd0, we_a}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_wd", {16'd0, wd_a}, 32'd0);
        check("rst_wa_a", wa_a, BASE_A);
        check("rst_wa_b", wa_b, BASE_B);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready_a}, 32'd0);

        // Three fixed words back to back
        q = '{16'h1111, 16'h2222, 16'h3333};
        do_load(q, 0, '0);

        // Two words with three stall cycles before each
        q = '{16'hA5A5, 16'h5A5A};
        do_load(q, 3, '0);

        // Empty load
        q.delete();
        do_load(q, 0, '0);

        // Bad checksum then good checksum on the same words
        q = '{16'h0001, 16'h0002};
        do_load(q, 0, 16'd1);
        do_load(q, 0, '0);

        // Reset in the middle of a five-word load
        clear_monitor();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word(16'd5, 1'b0, 0);
        send_word(16'hBEEF, 1'b1, 0);
        send_word(16'hCAFE, 1'b1, 1);
        clear_monitor();
        in_valid = 1'b1;
        in_data  = 16'h7777;
        rst      = 1'b1;
        #1;
        check("midrst_we_a", {31'd0, we_a}, 32'd0);
        check("midrst_we_b", {31'd0, we_b}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_wa_a", wa_a, BASE_A);
        check("midrst_wa_b", wa_b, BASE_B);
        d = wd_a;
        check("midrst_wd", {16'd0, d}, 32'd0);
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_no_writes", 32'(mon_addr_a.size()), 32'd0);
        random_words(4, q);
        do_load(q, -1, '0);

        // Randomized loads with random stalls, ignored starts and checksum errors
        for (int t = 0; t < 8; t++) begin
            random_words(int'($urandom_range(24, 1)), q);
            d = ($urandom_range(1, 0) == 0) ? '0 : W'($urandom_range(65535, 1));
            do_load(q, -1, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
